// File: rtl/uart_top_module.sv
// UART loopback: 8-bit transmitter (start, 8 data LSB first, parity, stop) whose
// serial line feeds an on-chip receiver that checks parity and stop bit.
module uart_top_module #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sent,
  input  logic       p_sel,
  input  logic [1:0] baud_sel,
  input  logic [7:0] d_in,
  output logic       error,
  output logic [7:0] rx,
  output logic       test
);

  localparam int unsigned CW = $clog2(CLK_FREQ / 9600 + 1);

  localparam logic [CW-1:0] BIT_9600   = CW'(CLK_FREQ / 9600);
  localparam logic [CW-1:0] BIT_19200  = CW'(CLK_FREQ / 19200);
  localparam logic [CW-1:0] BIT_38400  = CW'(CLK_FREQ / 38400);
  localparam logic [CW-1:0] BIT_115200 = CW'(CLK_FREQ / 115200);

  function automatic logic [CW-1:0] bit_period(input logic [1:0] sel);
    logic [CW-1:0] p;
    case (sel)
      2'b00:   p = BIT_9600;
      2'b01:   p = BIT_19200;
      2'b10:   p = BIT_38400;
      default: p = BIT_115200;
    endcase
    return p;
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] tx_period_q, tx_period_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_par_q, tx_par_d;
  logic          test_q, test_d;
  logic          tx_bit_end;
  logic          line;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] rx_period_q, rx_period_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_perr_q, rx_perr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          error_q, error_d;
  logic          line_prev_q, line_prev_d;
  logic          rx_sample;

  // ---------------- transmitter ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_period_q <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      tx_par_q    <= 1'b0;
      test_q      <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_period_q <= tx_period_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      tx_par_q    <= tx_par_d;
      test_q      <= test_d;
    end
  end

  assign tx_bit_end = (tx_cnt_q == tx_period_q - CW'(1));

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_period_d = tx_period_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    tx_par_d    = tx_par_q;
    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (sent) begin
          tx_state_d  = TX_START;
          tx_cnt_d    = '0;
          tx_idx_d    = '0;
          tx_data_d   = d_in;
          tx_par_d    = (^d_in) ^ p_sel;
          tx_period_d = bit_period(baud_sel);
        end
      end
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_q == 3'd7) tx_state_d = TX_PARITY;
          else                  tx_idx_d   = tx_idx_q + 3'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_bit_end) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    line   = 1'b1;
    test_d = 1'b0;
    case (tx_state_q)
      TX_START:  line = 1'b0;
      TX_DATA:   line = tx_data_q[tx_idx_q];
      TX_PARITY: line = tx_par_q;
      TX_STOP:   test_d = tx_bit_end;
      default:   line = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_period_q <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_perr_q   <= 1'b0;
      rx_data_q   <= '0;
      error_q     <= 1'b0;
      line_prev_q <= 1'b1;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_period_q <= rx_period_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_perr_q   <= rx_perr_d;
      rx_data_q   <= rx_data_d;
      error_q     <= error_d;
      line_prev_q <= line_prev_d;
    end
  end

  // Edge is seen one cycle into the start bit, so the count starts at 1 and the
  // start-bit sample lands BIT/2 cycles after the line fell.
  assign rx_sample = (rx_state_q == RX_START)
                   ? (rx_cnt_q == (rx_period_q >> 1) - CW'(1))
                   : (rx_cnt_q == rx_period_q - CW'(1));

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_period_d = rx_period_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_perr_d   = rx_perr_q;
    rx_data_d   = rx_data_q;
    error_d     = error_q;
    line_prev_d = line;
    if (rx_state_q != RX_IDLE) begin
      rx_cnt_d = rx_sample ? '0 : rx_cnt_q + CW'(1);
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (line_prev_q && !line) begin
          rx_state_d  = RX_START;
          rx_cnt_d    = CW'(1);
          rx_period_d = bit_period(baud_sel);
        end
      end
      RX_START: begin
        if (rx_sample) begin
          rx_state_d = line ? RX_IDLE : RX_DATA;
          rx_idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {line, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_PARITY;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_perr_d  = line ^ (^rx_shift_q) ^ p_sel;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_data_d  = rx_shift_q;
          error_d    = rx_perr_q | ~line;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx    = rx_data_q;
    error = error_q;
    test  = test_q;
  end

endmodule

// File: tb/tb_uart_top_module.sv
// Directed loopback bench: expected {error, byte} pairs are queued as each frame is
// set up and compared against rx/error on the matching test pulse.
module tb_uart_top_module;

  // Scaled clock keeps the 9600-baud frames short.
  localparam int unsigned TB_CLK = 5_000_000;
  localparam int B_9600   = TB_CLK / 9600;
  localparam int B_115200 = TB_CLK / 115200;

  logic       clk = 1'b0;
  logic       reset;
  logic       sent;
  logic       p_sel;
  logic [1:0] baud_sel;
  logic [7:0] d_in;
  logic       error;
  logic [7:0] rx;
  logic       test;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_top_module #(.CLK_FREQ(TB_CLK)) dut (
    .clk      (clk),
    .reset    (reset),
    .sent     (sent),
    .p_sel    (p_sel),
    .baud_sel (baud_sel),
    .d_in     (d_in),
    .error    (error),
    .rx       (rx),
    .test     (test)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_test(input string tag, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at = cyc;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (test === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    check({tag, "_pulse_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rx"}, 32'(rx), 32'(e[7:0]));
      check({tag, "_error"}, 32'(error), 32'(e[8]));
    end
  endtask

  initial begin
    int t0, t1, t2, pulses;

    reset = 1'b0; sent = 1'b0; p_sel = 1'b0; baud_sel = 2'b00; d_in = 8'hAA;
    #12;
    check("reset_rx", 32'(rx), 32'h00);
    check("reset_error", 32'(error), 32'd0);
    check("reset_test", 32'(test), 32'd0);

    // Even parity, 9600: two back-to-back frames of 0xAA
    sent = 1'b1;
    sb.push_back({1'b0, 8'hAA});
    #18 reset = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    repeat (5 * B_9600) @(negedge clk);
    check("pre_frame_rx", 32'(rx), 32'h00);
    check("pre_frame_test", 32'(test), 32'd0);
    wait_test("f1", 11 * B_9600 + 10, t1);
    check("f1_latency", 32'(t1 - t0), 32'(11 * B_9600));
    pop_check("f1");
    sb.push_back({1'b0, 8'hAA});
    wait_test("f2", 11 * B_9600 + 10, t2);
    check("f2_period", 32'(t2 - t1), 32'(11 * B_9600 + 1));
    pop_check("f2");

    // Odd parity, 115200
    baud_sel = 2'b11; p_sel = 1'b1; d_in = 8'h37;
    sb.push_back({1'b0, 8'h37});
    t1 = t2;
    wait_test("f3", 11 * B_115200 + 10, t2);
    check("f3_period", 32'(t2 - t1), 32'(11 * B_115200 + 1));
    pop_check("f3");

    // Reload on test, with mid-frame d_in disturbance
    d_in = 8'h01; sb.push_back({1'b0, 8'h01});
    repeat (100) @(negedge clk);
    d_in = 8'h5A;
    wait_test("f4", 11 * B_115200 + 10, t2);
    pop_check("f4");
    d_in = 8'hFE; sb.push_back({1'b0, 8'hFE});
    repeat (100) @(negedge clk);
    d_in = 8'h00;
    wait_test("f5", 11 * B_115200 + 10, t2);
    pop_check("f5");
    d_in = 8'h80; sb.push_back({1'b0, 8'h80});
    wait_test("f6", 11 * B_115200 + 10, t2);
    pop_check("f6");

    // Parity error: p_sel flips after the start bit, before the parity sample
    d_in = 8'h01; sb.push_back({1'b1, 8'h01});
    repeat (100) @(negedge clk);
    p_sel = 1'b0;
    wait_test("f7", 11 * B_115200 + 10, t2);
    pop_check("f7");
    d_in = 8'h3C; sb.push_back({1'b0, 8'h3C});
    wait_test("f8", 11 * B_115200 + 10, t2);
    pop_check("f8");

    // Idle: no frames while sent is low
    sent = 1'b0;
    @(negedge clk);
    check("test_width", 32'(test), 32'd0);
    pulses = 0;
    repeat (3 * (11 * B_115200 + 1)) begin
      @(negedge clk);
      if (test === 1'b1) pulses++;
    end
    check("idle_no_test", 32'(pulses), 32'd0);
    check("idle_rx_held", 32'(rx), 32'h3C);
    check("idle_error_held", 32'(error), 32'd0);

    // Mid-frame reset, then a clean frame
    d_in = 8'hC3; sent = 1'b1;
    sb.push_back({1'b0, 8'hC3});
    repeat (200) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_rx", 32'(rx), 32'h00);
    check("midreset_error", 32'(error), 32'd0);
    check("midreset_test", 32'(test), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    wait_test("f9", 11 * B_115200 + 10, t1);
    check("f9_latency", 32'(t1 - t0), 32'(11 * B_115200));
    pop_check("f9");
    sent = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
